// File: rtl/riscv_bp_track_pkg.sv
// riscv_bp_track_pkg: shared types and constants for the branch-prediction
// tracking slice.
//   bp_pred_t - 2-bit correlating-predictor counter value.
//   BP_*      - counter states in the predictor's 00<->01<->11<->10 walk.
//               Bit 1 is the predicted direction (1 = taken).
package riscv_bp_track_pkg;

  typedef logic [1:0] bp_pred_t;

  localparam bp_pred_t BP_STRONG_NT = 2'b00;
  localparam bp_pred_t BP_WEAK_NT   = 2'b01;
  localparam bp_pred_t BP_WEAK_T    = 2'b11;
  localparam bp_pred_t BP_STRONG_T  = 2'b10;

  // Predicted direction carried by a counter value.
  function automatic logic bp_dir(bp_pred_t p);
    return p[1];
  endfunction

endpackage

// File: rtl/riscv_bp_track_if.sv
// riscv_bp_track_if: branch-unit resolution bus between the tracker and the
// branch unit / predictor write port.
//   ex_branch_i, ex_btaken_i  branch unit -> tracker (EX branch, outcome)
//   bu_bp_*_o, bu_mispredict_o tracker -> predictor update side
// slave  = tracker side, master = branch-unit side.
interface riscv_bp_track_if
  import riscv_bp_track_pkg::*;
#(
  parameter int BP_GLOBAL_BITS = 2
);
  logic                      ex_branch_i;
  logic                      ex_btaken_i;
  logic [BP_GLOBAL_BITS-1:0] bu_bp_history_o;
  bp_pred_t                  bu_bp_predict_o;
  logic                      bu_bp_btaken_o;
  logic                      bu_bp_update_o;
  logic                      bu_mispredict_o;

  modport slave (
    input  ex_branch_i, ex_btaken_i,
    output bu_bp_history_o, bu_bp_predict_o, bu_bp_btaken_o,
           bu_bp_update_o, bu_mispredict_o
  );

  modport master (
    output ex_branch_i, ex_btaken_i,
    input  bu_bp_history_o, bu_bp_predict_o, bu_bp_btaken_o,
           bu_bp_update_o, bu_mispredict_o
  );
endinterface

// File: rtl/riscv_bp_track_sat_cnt.sv
// riscv_sat_cnt: W-bit saturating event counter.
//   clk_i, rst_ni  clock, async active-low reset
//   clr_i          synchronous clear, wins over inc_i
//   inc_i          count one event; sticks at all-ones
//   cnt_o          current count
module riscv_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                 cnt_d = '0;
    else if (inc_i && !(&cnt_q)) cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/riscv_bp_track.sv
// riscv_bp_track: carries predictor bits from the prediction RAM through ID
// and EX, keeps the global history register, drives the predictor update at
// branch resolution and counts branches / mispredicts.
//   clk_i, rst_ni          clock, async active-low reset
//   bp_bp_predict_i        predictor RAM output, aligned with the ID instruction
//   id_valid_i/id_stall_i  ID stage state
//   ex_stall_i             EX stage stall
//   pipe_flush_i           kill ID and EX contents
//   bu                     branch-unit resolution bus (slave side)
//   id_bp_predict_o        prediction of the instruction currently in ID
//   cnt_clr_i              clear both statistics counters
//   branch_cnt_o           resolved branches (saturating)
//   mispredict_cnt_o       mispredicted branches (saturating)
module riscv_bp_track
  import riscv_bp_track_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int HAS_BPU        = 0,
  parameter int BP_GLOBAL_BITS = 2,
  parameter int CNT_BITS       = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  bp_pred_t            bp_bp_predict_i,
  input  logic                id_valid_i,
  input  logic                id_stall_i,
  input  logic                ex_stall_i,
  input  logic                pipe_flush_i,
  riscv_bp_track_if.slave     bu,
  output bp_pred_t            id_bp_predict_o,
  input  logic                cnt_clr_i,
  output logic [CNT_BITS-1:0] branch_cnt_o,
  output logic [CNT_BITS-1:0] mispredict_cnt_o
);

  if (XLEN < 1 || BP_GLOBAL_BITS < 1) begin : g_bad_param
    $error("riscv_bp_track: XLEN and BP_GLOBAL_BITS must be >= 1");
  end

  localparam logic BPU_ON = (HAS_BPU != 0);

  bp_pred_t                  bp_in, id_out;
  bp_pred_t                  id_pred_q, id_pred_d, ex_pred_q, ex_pred_d;
  logic                      id_fresh_q;
  logic                      ex_valid_q, ex_valid_d;
  logic [BP_GLOBAL_BITS-1:0] ghr_q, ghr_d, ghr_shift;
  logic                      resolve, mispredict;

  // With the predictor absent every prediction reads as strongly not-taken.
  assign bp_in  = BPU_ON ? bp_bp_predict_i : BP_STRONG_NT;
  // The RAM output is only valid in the first ID cycle; afterwards the copy
  // latched from that cycle is used, so long ID stalls keep the right bits.
  assign id_out = id_fresh_q ? bp_in : id_pred_q;

  assign resolve    = ex_valid_q & bu.ex_branch_i & ~ex_stall_i;
  assign mispredict = resolve & (bp_dir(ex_pred_q) ^ bu.ex_btaken_i);

  if (BP_GLOBAL_BITS == 1) begin : g_ghr1
    assign ghr_shift = bu.ex_btaken_i;
  end else begin : g_ghrn
    assign ghr_shift = {ghr_q[BP_GLOBAL_BITS-2:0], bu.ex_btaken_i};
  end

  always_comb begin
    id_pred_d  = id_out;
    ex_valid_d = ex_valid_q;
    ex_pred_d  = ex_pred_q;
    ghr_d      = ghr_q;
    if (pipe_flush_i) begin
      id_pred_d  = BP_STRONG_NT;
      ex_valid_d = 1'b0;
      ex_pred_d  = BP_STRONG_NT;
    end else if (!ex_stall_i && id_stall_i) begin
      ex_valid_d = 1'b0;                // bubble into EX
    end else if (!ex_stall_i) begin
      ex_valid_d = id_valid_i;
      ex_pred_d  = id_out;
    end
    // History uses the pre-flush EX content; it is never rolled back.
    if (resolve && BPU_ON) ghr_d = ghr_shift;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_pred_q  <= BP_STRONG_NT;
      id_fresh_q <= 1'b0;
      ex_valid_q <= 1'b0;
      ex_pred_q  <= BP_STRONG_NT;
      ghr_q      <= '0;
    end else begin
      id_pred_q  <= id_pred_d;
      id_fresh_q <= ~id_stall_i;
      ex_valid_q <= ex_valid_d;
      ex_pred_q  <= ex_pred_d;
      ghr_q      <= ghr_d;
    end
  end

  assign id_bp_predict_o    = id_out;
  assign bu.bu_bp_history_o = ghr_q;
  assign bu.bu_bp_predict_o = ex_pred_q;
  assign bu.bu_bp_btaken_o  = bu.ex_btaken_i;
  assign bu.bu_bp_update_o  = resolve & BPU_ON;
  assign bu.bu_mispredict_o = mispredict;

  riscv_sat_cnt #(.W(CNT_BITS)) u_branch_cnt (
    .clk_i (clk_i), .rst_ni (rst_ni), .clr_i (cnt_clr_i),
    .inc_i (resolve), .cnt_o (branch_cnt_o)
  );

  riscv_sat_cnt #(.W(CNT_BITS)) u_mispredict_cnt (
    .clk_i (clk_i), .rst_ni (rst_ni), .clr_i (cnt_clr_i),
    .inc_i (mispredict), .cnt_o (mispredict_cnt_o)
  );

endmodule

// File: tb/tb_riscv_bp_track.sv
// Directed bench: predictor-enabled instance (CNT_BITS=4) plus a
// predictor-disabled instance sharing the same stimulus.
module tb_riscv_bp_track;
  import riscv_bp_track_pkg::*;

  logic       clk, rst_ni;
  bp_pred_t   bp_i;
  logic       id_valid, id_stall, ex_stall, flush, ex_branch, ex_btaken, cnt_clr;
  bp_pred_t   id_pred, id_pred0;
  logic [3:0] bcnt, mcnt, bcnt0, mcnt0;
  int         n_vec = 0;
  int         n_err = 0;

  riscv_bp_track_if #(.BP_GLOBAL_BITS(2)) bu_if ();
  riscv_bp_track_if #(.BP_GLOBAL_BITS(2)) bu0_if ();

  assign bu_if.ex_branch_i  = ex_branch;
  assign bu_if.ex_btaken_i  = ex_btaken;
  assign bu0_if.ex_branch_i = ex_branch;
  assign bu0_if.ex_btaken_i = ex_btaken;

  riscv_bp_track #(.XLEN(32), .HAS_BPU(1), .BP_GLOBAL_BITS(2), .CNT_BITS(4)) dut (
    .clk_i (clk), .rst_ni (rst_ni), .bp_bp_predict_i (bp_i),
    .id_valid_i (id_valid), .id_stall_i (id_stall), .ex_stall_i (ex_stall),
    .pipe_flush_i (flush), .bu (bu_if), .id_bp_predict_o (id_pred),
    .cnt_clr_i (cnt_clr), .branch_cnt_o (bcnt), .mispredict_cnt_o (mcnt)
  );

  riscv_bp_track #(.XLEN(32), .HAS_BPU(0), .BP_GLOBAL_BITS(2), .CNT_BITS(4)) dut0 (
    .clk_i (clk), .rst_ni (rst_ni), .bp_bp_predict_i (bp_i),
    .id_valid_i (id_valid), .id_stall_i (id_stall), .ex_stall_i (ex_stall),
    .pipe_flush_i (flush), .bu (bu0_if), .id_bp_predict_o (id_pred0),
    .cnt_clr_i (cnt_clr), .branch_cnt_o (bcnt0), .mispredict_cnt_o (mcnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bp_i = 2'b00; id_valid = 0; id_stall = 0; ex_stall = 0;
    flush = 0; ex_branch = 0; ex_btaken = 0; cnt_clr = 0;
  endtask

  // Put an instruction with prediction p into ID for one cycle; it is in EX afterwards.
  task automatic load(input bp_pred_t p);
    bp_i = p; id_valid = 1;
    tick();
    idle();
  endtask

  initial begin
    idle();
    rst_ni = 1;
    #2 rst_ni = 0;
    #1;
    chk("rst_id",   32'(id_pred), 0);
    chk("rst_hist", 32'(bu_if.bu_bp_history_o), 0);
    chk("rst_upd",  32'(bu_if.bu_bp_update_o), 0);
    chk("rst_bcnt", 32'(bcnt), 0);
    tick(); tick();
    rst_ni = 1;
    tick();

    // Prediction alignment: 10 predicted, resolves not-taken.
    bp_i = 2'b10; id_valid = 1;
    #1;
    chk("al_id",  32'(id_pred), 32'h2);
    chk("al_id0", 32'(id_pred0), 0);
    tick(); idle();
    ex_branch = 1; ex_btaken = 0;
    #1;
    chk("al_pred", 32'(bu_if.bu_bp_predict_o), 32'h2);
    chk("al_upd",  32'(bu_if.bu_bp_update_o), 1);
    chk("al_mis",  32'(bu_if.bu_mispredict_o), 1);
    chk("al_hist", 32'(bu_if.bu_bp_history_o), 0);
    chk("al_btk",  32'(bu_if.bu_bp_btaken_o), 0);
    chk("al_upd0", 32'(bu0_if.bu_bp_update_o), 0);
    chk("al_mis0", 32'(bu0_if.bu_mispredict_o), 0);
    tick(); idle(); #1;
    chk("al_ghr",   32'(bu_if.bu_bp_history_o), 0);
    chk("al_bcnt",  32'(bcnt), 1);
    chk("al_mcnt",  32'(mcnt), 1);
    chk("al_bcnt0", 32'(bcnt0), 1);
    chk("al_mcnt0", 32'(mcnt0), 0);

    // Correct taken branch: ghr 00 -> 01.
    load(2'b11);
    ex_branch = 1; ex_btaken = 1;
    #1;
    chk("t_mis",  32'(bu_if.bu_mispredict_o), 0);
    chk("t_mis0", 32'(bu0_if.bu_mispredict_o), 1);
    tick(); idle(); #1;
    chk("t_ghr",  32'(bu_if.bu_bp_history_o), 32'h1);
    chk("t_bcnt", 32'(bcnt), 2);

    // Three-cycle EX stall on a taken branch.
    load(2'b10);
    ex_branch = 1; ex_btaken = 1; ex_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_upd", 32'(bu_if.bu_bp_update_o), 0);
      tick();
    end
    chk("st_bcnt", 32'(bcnt), 2);
    ex_stall = 0;
    #1;
    chk("st_rel_upd",  32'(bu_if.bu_bp_update_o), 1);
    chk("st_rel_hist", 32'(bu_if.bu_bp_history_o), 32'h1);
    chk("st_rel_mis",  32'(bu_if.bu_mispredict_o), 0);
    tick(); idle(); #1;
    chk("st_ghr",  32'(bu_if.bu_bp_history_o), 32'h3);
    chk("st_bcnt1", 32'(bcnt), 3);

    // ID stall across changing RAM output 11 -> 00 -> 01.
    bp_i = 2'b11; id_valid = 1; id_stall = 1; ex_branch = 1;
    #1;
    chk("is_id0",  32'(id_pred), 32'h3);
    chk("is_upd0", 32'(bu_if.bu_bp_update_o), 0);
    tick();
    bp_i = 2'b00;
    #1;
    chk("is_id1",  32'(id_pred), 32'h3);
    chk("is_upd1", 32'(bu_if.bu_bp_update_o), 0);
    tick();
    bp_i = 2'b01; id_stall = 0; ex_branch = 0;
    #1;
    chk("is_id2", 32'(id_pred), 32'h3);
    tick(); idle();
    ex_branch = 1; ex_btaken = 0;
    #1;
    chk("is_pred", 32'(bu_if.bu_bp_predict_o), 32'h3);
    chk("is_upd",  32'(bu_if.bu_bp_update_o), 1);
    chk("is_mis",  32'(bu_if.bu_mispredict_o), 1);
    tick(); idle(); #1;
    chk("is_ghr",  32'(bu_if.bu_bp_history_o), 32'h2);
    chk("is_mcnt", 32'(mcnt), 2);

    // Flush on the same edge as a resolving branch.
    load(2'b10);
    ex_branch = 1; ex_btaken = 1; flush = 1; id_valid = 1; bp_i = 2'b11;
    #1;
    chk("fl_upd",  32'(bu_if.bu_bp_update_o), 1);
    chk("fl_mis",  32'(bu_if.bu_mispredict_o), 0);
    chk("fl_pred", 32'(bu_if.bu_bp_predict_o), 32'h2);
    tick(); idle();
    ex_branch = 1;
    #1;
    chk("fl_upd_nx", 32'(bu_if.bu_bp_update_o), 0);
    chk("fl_ghr",    32'(bu_if.bu_bp_history_o), 32'h1);
    chk("fl_bcnt",   32'(bcnt), 5);
    tick(); idle();

    // Bring ghr to 11, then reset mid-run with a branch about to resolve.
    load(2'b11);
    ex_branch = 1; ex_btaken = 1;
    tick(); idle(); #1;
    chk("pre_ghr",  32'(bu_if.bu_bp_history_o), 32'h3);
    chk("pre_bcnt", 32'(bcnt), 6);
    chk("pre_mcnt", 32'(mcnt), 2);
    load(2'b10);
    ex_branch = 1; bp_i = 2'b11; id_valid = 1;
    #1 rst_ni = 0;
    #1;
    chk("mr_id",   32'(id_pred), 0);
    chk("mr_hist", 32'(bu_if.bu_bp_history_o), 0);
    chk("mr_pred", 32'(bu_if.bu_bp_predict_o), 0);
    chk("mr_upd",  32'(bu_if.bu_bp_update_o), 0);
    chk("mr_mis",  32'(bu_if.bu_mispredict_o), 0);
    chk("mr_bcnt", 32'(bcnt), 0);
    chk("mr_mcnt", 32'(mcnt), 0);
    tick();
    rst_ni = 1; idle();
    tick();
    load(2'b11);
    ex_branch = 1; ex_btaken = 1;
    #1;
    chk("ar_hist", 32'(bu_if.bu_bp_history_o), 0);
    chk("ar_upd",  32'(bu_if.bu_bp_update_o), 1);
    tick(); idle(); #1;
    chk("ar_ghr",  32'(bu_if.bu_bp_history_o), 32'h1);
    chk("ar_bcnt", 32'(bcnt), 1);

    // Back-to-back taken branches predicted not-taken: both counters saturate.
    id_valid = 1; bp_i = 2'b00; ex_branch = 1; ex_btaken = 1;
    repeat (20) tick();
    chk("sat_bcnt", 32'(bcnt), 15);
    chk("sat_mcnt", 32'(mcnt), 15);
    cnt_clr = 1;
    #1;
    chk("clr_upd", 32'(bu_if.bu_bp_update_o), 1);
    tick();
    chk("clr_bcnt", 32'(bcnt), 0);
    chk("clr_mcnt", 32'(mcnt), 0);
    cnt_clr = 0;
    tick();
    chk("post_bcnt", 32'(bcnt), 1);
    chk("post_mcnt", 32'(mcnt), 1);
    chk("nobpu_ghr", 32'(bu0_if.bu_bp_history_o), 0);
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
